lfsr_run_ctrl: RTL and testbench

- Run sequencer for the LFSR + 12-bit sequence-detector datapath.
- On a start request it performs four steps in order: clears the detector, seeds the LFSR, enables it for either a fixed cycle count or one full period (until max_tick), then captures the detector's match count.
- It compares that count against an expected value and reports a 2-bit status with a one-cycle done pulse.
- Sits between the test/host logic and the LFSR/detector pair.

---
 rtl/lfsr_ctrl_pkg.sv | 26 ++
 rtl/lfsr_run_ctrl_run_timer.sv | 36 +++
 rtl/lfsr_run_ctrl.sv | 140 ++++++++++++++
 tb/tb_lfsr_run_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared encodings for the LFSR run sequencer: FSM states and run status codes.
package lfsr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ST_PASS     = 2'b00,
    ST_MISMATCH = 2'b01,
    ST_TIMEOUT  = 2'b10,
    ST_ABORT    = 2'b11
  } status_t;

  // States in which an abort request cancels the run.
  function automatic logic abortable(input state_t s);
    return (s == CLEAR) || (s == LOAD) || (s == RUN) || (s == DRAIN) || (s == CHECK);
  endfunction

endpackage

// File: rtl/lfsr_run_ctrl_run_timer.sv
// Cycle counter for the RUN phase, with terminal flags for the programmed
// run length and for the period-mode timeout.
module run_timer #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 8191
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [LEN_W-1:0] run_len,
  output logic [LEN_W-1:0] count,
  output logic             len_hit,
  output logic             tmo_hit
);

  localparam logic [LEN_W-1:0] TMO_LAST = LEN_W'(TIMEOUT - 1);

  // Counter: clear wins over enable; never wraps in legal use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + LEN_W'(1);
    end
  end

  // Terminal flags: true during the last counted cycle.
  always_comb begin
    len_hit = (run_len != '0) && (count == (run_len - LEN_W'(1)));
    tmo_hit = (count == TMO_LAST);
  end

endmodule

// File: rtl/lfsr_run_ctrl.sv
// Run sequencer for the LFSR + sequence-detector pair: clear detector, seed
// LFSR, run it for a fixed count or one full period, capture and judge the
// detector's match count, then pulse done with a 2-bit status.
module lfsr_run_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int unsigned LFSR_W  = 12,
  parameter int unsigned CNT_W   = 9,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 8191
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [LEN_W-1:0]  run_len,
  input  logic [CNT_W-1:0]  expected_cnt,
  input  logic              max_tick,
  input  logic [CNT_W-1:0]  det_count,
  output logic              det_rst_n,
  output logic              lfsr_load,
  output logic [LFSR_W-1:0] lfsr_seed,
  output logic              lfsr_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  result_cnt,
  output logic [LEN_W-1:0]  cycles_run
);

  state_t            state_q, state_d;
  status_t           status_q;
  logic [LFSR_W-1:0] seed_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  exp_q;
  logic [CNT_W-1:0]  result_q;
  logic [LEN_W-1:0]  cycles_q;

  logic [LEN_W-1:0]  cnt;
  logic              len_hit, tmo_hit;
  logic              fixed_mode, abort_ok, tick_take, tmo_take, run_exit;

  run_timer #(
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state_q == IDLE) && start),
    .en      (state_q == RUN),
    .run_len (len_q),
    .count   (cnt),
    .len_hit (len_hit),
    .tmo_hit (tmo_hit)
  );

  // Qualified events; abort outranks every RUN termination.
  always_comb begin
    fixed_mode = (len_q != '0);
    abort_ok   = abort && abortable(state_q);
    tick_take  = (state_q == RUN) && !abort && !fixed_mode && max_tick;
    tmo_take   = (state_q == RUN) && !abort && !fixed_mode && !max_tick && tmo_hit;
    run_exit   = (state_q == RUN) && (state_d != RUN);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides the normal successor of any active state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: state_d = LOAD;
      LOAD:  state_d = RUN;
      RUN: begin
        if (fixed_mode ? len_hit : max_tick) begin
          state_d = DRAIN;
        end else if (!fixed_mode && tmo_hit) begin
          state_d = DONE;
        end
      end
      DRAIN: state_d = CHECK;
      CHECK: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_ok) state_d = DONE;
  end

  // Moore output decode; detector reset also follows the system reset.
  always_comb begin
    det_rst_n = rst_n && (state_q != CLEAR);
    lfsr_load = (state_q == LOAD);
    lfsr_en   = (state_q == RUN);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  // Run parameters, captured count, cycle tally and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q   <= '0;
      len_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      cycles_q <= '0;
      status_q <= ST_PASS;
    end else begin
      if ((state_q == IDLE) && start) begin
        seed_q <= seed_in;
        len_q  <= run_len;
        exp_q  <= expected_cnt;
      end
      // The counter also advances on the exit edge, so the tally is cnt+1.
      if (run_exit) cycles_q <= cnt + LEN_W'(1);
      if (abort_ok) begin
        status_q <= ST_ABORT;
      end else begin
        if (tick_take) result_q <= det_count;
        if (tmo_take) status_q <= ST_TIMEOUT;
        if ((state_q == DRAIN) && fixed_mode) result_q <= det_count;
        if (state_q == CHECK) status_q <= (result_q == exp_q) ? ST_PASS : ST_MISMATCH;
      end
    end
  end

  assign lfsr_seed  = seed_q;
  assign status     = status_q;
  assign result_cnt = result_q;
  assign cycles_run = cycles_q;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Scoreboard bench for lfsr_run_ctrl: two instances (default timeout and a
// short one) share stimulus; a detector model drives det_count and max_tick.
module tb_lfsr_run_ctrl;

  localparam int LFSR_W = 12;
  localparam int CNT_W  = 9;
  localparam int LEN_W  = 16;
  localparam int TMO_M  = 8191;
  localparam int TMO_T  = 20;

  logic clk = 1'b0;
  logic rst_n, start, abort, max_tick;
  logic [LFSR_W-1:0] seed_in;
  logic [LEN_W-1:0]  run_len;
  logic [CNT_W-1:0]  expected_cnt;
  logic [CNT_W-1:0]  det_count;

  logic              det_rst_n_m, lfsr_load_m, lfsr_en_m, busy_m, done_m;
  logic [LFSR_W-1:0] lfsr_seed_m;
  logic [1:0]        status_m;
  logic [CNT_W-1:0]  result_cnt_m;
  logic [LEN_W-1:0]  cycles_run_m;

  logic              det_rst_n_t, lfsr_load_t, lfsr_en_t, busy_t, done_t;
  logic [LFSR_W-1:0] lfsr_seed_t;
  logic [1:0]        status_t;
  logic [CNT_W-1:0]  result_cnt_t;
  logic [LEN_W-1:0]  cycles_run_t;

  always #5 clk = ~clk;

  lfsr_run_ctrl #(.LFSR_W(LFSR_W), .CNT_W(CNT_W), .LEN_W(LEN_W), .TIMEOUT(TMO_M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed_in(seed_in),
    .run_len(run_len), .expected_cnt(expected_cnt), .max_tick(max_tick),
    .det_count(det_count), .det_rst_n(det_rst_n_m), .lfsr_load(lfsr_load_m),
    .lfsr_seed(lfsr_seed_m), .lfsr_en(lfsr_en_m), .busy(busy_m), .done(done_m),
    .status(status_m), .result_cnt(result_cnt_m), .cycles_run(cycles_run_m)
  );

  lfsr_run_ctrl #(.LFSR_W(LFSR_W), .CNT_W(CNT_W), .LEN_W(LEN_W), .TIMEOUT(TMO_T)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed_in(seed_in),
    .run_len(run_len), .expected_cnt(expected_cnt), .max_tick(max_tick),
    .det_count(det_count), .det_rst_n(det_rst_n_t), .lfsr_load(lfsr_load_t),
    .lfsr_seed(lfsr_seed_t), .lfsr_en(lfsr_en_t), .busy(busy_t), .done(done_t),
    .status(status_t), .result_cnt(result_cnt_t), .cycles_run(cycles_run_t)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Detector model (follows the default-timeout instance): sync clear, one
  // match per listed enable index, self-clear on the period tick.
  int en_idx = 0;
  int tick_at = 0;
  int hit_idx[3] = '{-1, -1, -1};

  always @(posedge clk) begin
    if (!det_rst_n_m) begin
      det_count <= '0;
      en_idx    <= 0;
    end else if (lfsr_en_m) begin
      en_idx <= en_idx + 1;
      if (max_tick) det_count <= '0;
      else if (en_idx == hit_idx[0] || en_idx == hit_idx[1] || en_idx == hit_idx[2])
        det_count <= det_count + 1'b1;
    end
  end

  assign max_tick = lfsr_en_m && (tick_at != 0) && (en_idx == tick_at - 1);

  typedef struct {
    string            tag;
    int               lat;
    logic [1:0]       st;
    bit               chk_res;
    logic [CNT_W-1:0] res;
    logic [LEN_W-1:0] cr;
  } exp_t;

  exp_t q_m[$];
  exp_t q_t[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outcome of one run, from the run parameters and the hit schedule.
  function automatic exp_t predict(input string tag, input int len, input int tick,
                                   input int tmo, input int abort_run,
                                   input logic [CNT_W-1:0] exp_cnt, input int c);
    exp_t e;
    int end_run, limit, hits;
    bit ticked;
    ticked = (len == 0) && (tick != 0) && (tick <= tmo);
    end_run = (len != 0) ? len : (ticked ? tick : tmo);
    e.tag = tag;
    e.chk_res = 1'b0;
    e.res = '0;
    if (abort_run != 0 && abort_run <= end_run) begin
      e.st = 2'b11; e.cr = LEN_W'(abort_run); e.lat = c + abort_run + 3;
    end else if (len == 0 && !ticked) begin
      e.st = 2'b10; e.cr = LEN_W'(tmo); e.lat = c + tmo + 3;
    end else begin
      limit = (len != 0) ? len : tick - 1;
      hits = 0;
      for (int k = 0; k < 3; k++) if (hit_idx[k] >= 0 && hit_idx[k] < limit) hits++;
      e.chk_res = 1'b1;
      e.res = CNT_W'(hits);
      e.st = (CNT_W'(hits) == exp_cnt) ? 2'b00 : 2'b01;
      e.cr = LEN_W'(end_run);
      e.lat = c + end_run + 5;
    end
    return e;
  endfunction

  task automatic judge(input exp_t e, input string who, input logic [1:0] st,
                       input logic [CNT_W-1:0] res, input logic [LEN_W-1:0] cr,
                       input int en, input int ld, input int clr);
    string t;
    t = {e.tag, who};
    check({t, "_status"}, st, e.st);
    if (e.chk_res) check({t, "_result"}, res, e.res);
    check({t, "_cycles_run"}, cr, e.cr);
    check({t, "_en_cycles"}, en, e.cr);
    check({t, "_load_cycles"}, ld, 1);
    check({t, "_clear_cycles"}, clr, 1);
    check({t, "_done_cycle"}, cyc, e.lat);
  endtask

  // Watches both instances until each has pulsed done and returned idle.
  task automatic run_watch(input string tag, input logic [LFSR_W-1:0] seed, input int abort_run);
    int en_m = 0, ld_m = 0, clr_m = 0, en_t = 0, ld_t = 0, clr_t = 0;
    bit got_m = 0, got_t = 0, post_m = 0, post_t = 0;
    exp_t e;
    for (int i = 0; i < 20000 && !(got_m && got_t); i++) begin
      @(negedge clk);
      if (post_m) begin
        check({tag, "_m_idle_after"}, {busy_m, done_m}, 2'b00);
        post_m = 0; got_m = 1;
      end else if (!got_m) begin
        en_m += int'(lfsr_en_m); ld_m += int'(lfsr_load_m); clr_m += int'(!det_rst_n_m);
        if (lfsr_load_m) check({tag, "_m_seed"}, lfsr_seed_m, seed);
        if (done_m) begin
          e = q_m.pop_front();
          judge(e, "_m", status_m, result_cnt_m, cycles_run_m, en_m, ld_m, clr_m);
          post_m = 1;
        end
      end
      if (post_t) begin
        check({tag, "_t_idle_after"}, {busy_t, done_t}, 2'b00);
        post_t = 0; got_t = 1;
      end else if (!got_t) begin
        en_t += int'(lfsr_en_t); ld_t += int'(lfsr_load_t); clr_t += int'(!det_rst_n_t);
        if (lfsr_load_t) check({tag, "_t_seed"}, lfsr_seed_t, seed);
        if (done_t) begin
          e = q_t.pop_front();
          judge(e, "_t", status_t, result_cnt_t, cycles_run_t, en_t, ld_t, clr_t);
          post_t = 1;
        end
      end
      if (i == 0) start = 1'b0;
      if (abort_run != 0 && i == abort_run + 1) begin
        abort = 1'b1; start = 1'b1;
      end else if (abort_run != 0 && i == abort_run + 2) begin
        abort = 1'b0; start = 1'b0;
      end
    end
    check({tag, "_completed"}, {got_m, got_t}, 2'b11);
  endtask

  task automatic launch(input string tag, input logic [LFSR_W-1:0] seed, input int len,
                        input int tick, input logic [CNT_W-1:0] expv, input int abort_run);
    @(negedge clk);
    seed_in = seed; run_len = LEN_W'(len); expected_cnt = expv; tick_at = tick;
    start = 1'b1;
    q_m.push_back(predict(tag, len, tick, TMO_M, abort_run, expv, cyc));
    q_t.push_back(predict(tag, len, tick, TMO_T, abort_run, expv, cyc));
    run_watch(tag, seed, abort_run);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    seed_in = '0; run_len = '0; expected_cnt = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl_m", {busy_m, done_m, lfsr_en_m, lfsr_load_m, det_rst_n_m}, 5'b0);
    check("rst_ctrl_t", {busy_t, done_t, lfsr_en_t, lfsr_load_t, det_rst_n_t}, 5'b0);
    check("rst_regs_m", {status_m, result_cnt_m, cycles_run_m, lfsr_seed_m}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release", {det_rst_n_m, busy_m, det_rst_n_t, busy_t}, 4'b1010);

    hit_idx = '{2, 6, 9};
    launch("fix", 12'hACE, 10, 0, 9'd3, 0);
    launch("mis", 12'hACE, 10, 0, 9'd2, 0);

    // Asynchronous reset during RUN cycle 7 of a 100-cycle run.
    @(negedge clk);
    seed_in = 12'h321; run_len = 16'd100; expected_cnt = 9'd0; tick_at = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_rst_in_run", lfsr_en_m, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {lfsr_en_m, busy_m, det_rst_n_m, lfsr_en_t, busy_t}, 5'b0);
    check("mid_rst_regs", {status_m, result_cnt_m, cycles_run_m, status_t}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_after", {busy_m, det_rst_n_m, lfsr_en_m, busy_t}, 4'b0100);

    hit_idx = '{100, -1, -1};
    launch("per", 12'h001, 0, 4095, 9'd1, 0);
    hit_idx = '{3, -1, -1};
    launch("tie", 12'h5A5, 0, 20, 9'd1, 0);
    hit_idx = '{-1, -1, -1};
    launch("tmo", 12'h123, 0, 0, 9'd0, 0);
    hit_idx = '{2, 6, 9};
    launch("abt", 12'hACE, 100, 0, 9'd3, 5);
    launch("abt_tc", 12'h0F0, 6, 0, 9'd0, 6);
    launch("post", 12'h7E1, 10, 0, 9'd3, 0);

    @(negedge clk);
    check("status_held", status_m, 2'b00);
    check("sb_drained", q_m.size() + q_t.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
